// File: rtl/bus_master_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_lsu_pkg
// Description : Shared types and constants for the load/store bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_master_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } access_size_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/bus_master_lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Byte-lane extraction/extension for loads, lane merge for
//               sub-word stores, and alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import bus_master_lsu_pkg::*;
(
    input  logic [31:0]  ld_word,
    input  logic [1:0]   ld_offset,
    input  access_size_t ld_size,
    input  logic         ld_unsigned,
    output logic [31:0]  ld_data,
    input  logic [31:0]  st_old_word,
    input  logic [15:0]  st_data,
    input  logic [1:0]   st_offset,
    input  access_size_t st_size,
    output logic [31:0]  st_word,
    output logic         misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = ld_word[{ld_offset, 3'b000} +: 8];
    assign w_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];

    assign misaligned = (ld_size == SZ_RSVD)
                     || ((ld_size == SZ_HALF) && ld_offset[0])
                     || ((ld_size == SZ_WORD) && (ld_offset != 2'b00));

    always_comb begin
        ld_data = '0;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & w_half[15]}}, w_half};
            SZ_WORD: ld_data = ld_word;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        st_word = st_old_word;
        case (st_size)
            SZ_BYTE: st_word[{st_offset, 3'b000} +: 8] = st_data[7:0];
            SZ_HALF: begin
                if (st_offset[1]) st_word[31:16] = st_data;
                else              st_word[15:0]  = st_data;
            end
            default: st_word = st_old_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_master_lsu.sv
`default_nettype none
// ============================================================================
// Module      : bus_master_lsu
// Description : Pipeline load/store to word-wide peripheral bus initiator with
//               read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_master_lsu
    import bus_master_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_write_data,
    output logic              bus_write_enable,
    input  logic [DATA_W-1:0] bus_read_data
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("bus_master_lsu supports DATA_W == 32 only");
    end

    lsu_state_t        r_state;
    lsu_state_t        w_state_next;
    logic              r_resp_valid;
    logic              r_resp_error;
    logic [DATA_W-1:0] r_resp_rdata;
    logic [DATA_W-1:0] r_old_word;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_offset;
    access_size_t      r_size;
    logic [15:0]       r_wdata;

    access_size_t      w_size;
    logic [ADDR_W-1:0] w_aligned_addr;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_rmw_start;
    logic              w_we;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merged;

    assign w_size         = access_size_t'(req_size);
    assign w_aligned_addr = {req_addr[ADDR_W-1:2], 2'b00};
    assign w_rmw_start    = w_accept && req_store && !w_misaligned && (w_size != SZ_WORD);

    lsu_lane_align u_lane_align (
        .ld_word     (bus_read_data),
        .ld_offset   (req_addr[1:0]),
        .ld_size     (w_size),
        .ld_unsigned (req_unsigned),
        .ld_data     (w_load_data),
        .st_old_word (r_old_word),
        .st_data     (r_wdata),
        .st_offset   (r_offset),
        .st_size     (r_size),
        .st_word     (w_merged),
        .misaligned  (w_misaligned)
    );

    always_comb begin
        w_state_next   = r_state;
        req_ready      = 1'b0;
        w_accept       = 1'b0;
        bus_address    = '0;
        bus_write_data = '0;
        w_we           = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                w_accept  = req_valid;
                if (req_valid && !w_misaligned) begin
                    bus_address = w_aligned_addr;
                    if (req_store && (w_size == SZ_WORD)) begin
                        bus_write_data = req_wdata;
                        w_we           = 1'b1;
                    end else if (req_store) begin
                        w_state_next = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                bus_address    = r_addr;
                bus_write_data = w_merged;
                w_we           = 1'b1;
                w_state_next   = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Reset must kill an in-flight RMW write in the very cycle it is sampled.
    assign bus_write_enable = w_we & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
            r_old_word   <= '0;
            r_addr       <= '0;
            r_offset     <= 2'b00;
            r_size       <= SZ_BYTE;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= (w_accept && !w_rmw_start) || (r_state == RMW_WR);
            r_resp_error <= w_accept && w_misaligned;
            r_resp_rdata <= (w_accept && !req_store && !w_misaligned) ? w_load_data : '0;
            if (w_rmw_start) begin
                r_old_word <= bus_read_data;
                r_addr     <= w_aligned_addr;
                r_offset   <= req_addr[1:0];
                r_size     <= w_size;
                r_wdata    <= req_wdata[15:0];
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_error = r_resp_error;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire
